// File: rtl/codec_init_seq.sv
// ---------------------------------------------------------------------------
// codec_init_seq
//   Power-up configuration sequencer for the WM8731 audio codec (DE2 board).
//   Walks a fixed 9-entry register table and issues one i2c_write transaction
//   per entry over the writer's write/done handshake, so that downstream audio
//   logic sees a codec set to I2S slave, 24-bit, DAC routed.
//
// Handshake (write/done): i2c_write is raised with addr/register/data stable
//   and held until i2c_done is sampled high; it then drops on that same edge.
//   The next entry is not started until i2c_done has been sampled low again.
//   i2c_done already high when the request is raised counts as completion.
//
// Ports
//   sys_clk       in   1  system clock (50 MHz)
//   rst           in   1  synchronous reset, active low
//   start         in   1  rising edge (sampled) launches the sequence
//   i2c_addr      out  8  device address byte (DEV_ADDR, constant)
//   i2c_register  out  8  {R[6:0], D[8]} of current entry
//   i2c_data      out  8  D[7:0] of current entry
//   i2c_write     out  1  write request, held until i2c_done seen high
//   i2c_done      in   1  completion from the I2C writer
//   busy          out  1  high in GAP/REQ/RELEASE
//   cfg_done      out  1  sticky: all entries written
//   cfg_error     out  1  sticky: writer timeout occurred
//   entry_idx     out  4  index of current / failing entry
//   state_dbg     out  3  FSM state (0 IDLE,1 GAP,2 REQ,3 RELEASE,4 DONE,5 ERROR)
// ---------------------------------------------------------------------------
module codec_init_seq #(
  parameter logic [7:0]  DEV_ADDR       = 8'h34,
  parameter int unsigned GAP_CYCLES     = 5_000,
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] i2c_addr,
  output logic [7:0] i2c_register,
  output logic [7:0] i2c_data,
  output logic       i2c_write,
  input  logic       i2c_done,
  output logic       busy,
  output logic       cfg_done,
  output logic       cfg_error,
  output logic [3:0] entry_idx,
  output logic [2:0] state_dbg
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       LAST_ENTRY = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GAP     = 3'd1,
    S_REQ     = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4,
    S_ERROR   = 3'd5
  } state_e;

  state_e           state_q;
  logic             start_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic [3:0]       entry_q;
  logic [7:0]       reg_q;
  logic [7:0]       data_q;
  logic             write_q;
  logic             busy_q;
  logic             done_q;
  logic             error_q;

  logic             start_edge;
  logic [GAP_W-1:0] gap_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_d;
  logic [3:0]       entry_d;
  logic             tmo_hit;

  // Register table as {R[6:0], D[8:0]}; the 16-bit word splits directly
  // into the register byte and data byte sent to the codec.
  function automatic logic [15:0] table_word(input logic [3:0] idx);
    logic [6:0] r;
    logic [8:0] d;
    case (idx)
      4'd0:    begin r = 7'd15; d = 9'h000; end  // reset
      4'd1:    begin r = 7'd6;  d = 9'h000; end  // power on all blocks
      4'd2:    begin r = 7'd2;  d = 9'h079; end  // left headphone volume
      4'd3:    begin r = 7'd3;  d = 9'h079; end  // right headphone volume
      4'd4:    begin r = 7'd4;  d = 9'h010; end  // DACSEL
      4'd5:    begin r = 7'd5;  d = 9'h000; end  // digital path, no mute
      4'd6:    begin r = 7'd7;  d = 9'h00A; end  // I2S, 24-bit, slave
      4'd7:    begin r = 7'd8;  d = 9'h000; end  // normal mode, 48 kHz
      default: begin r = 7'd9;  d = 9'h001; end  // active
    endcase
    return {r, d};
  endfunction

  assign start_edge = start & ~start_q;
  assign gap_cnt_d  = gap_cnt_q + GAP_W'(1);
  assign tmo_cnt_d  = tmo_cnt_q + TMO_W'(1);
  assign entry_d    = entry_q + 4'd1;
  // The timeout counter would reach TIMEOUT_CYCLES on this edge.
  assign tmo_hit    = (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      gap_cnt_q <= '0;
      tmo_cnt_q <= '0;
      entry_q   <= 4'd0;
      reg_q     <= 8'h00;
      data_q    <= 8'h00;
      write_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      start_q <= start;
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_edge) begin
            state_q   <= S_GAP;
            entry_q   <= 4'd0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            busy_q    <= 1'b1;
            gap_cnt_q <= '0;
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q   <= S_REQ;
            write_q   <= 1'b1;
            tmo_cnt_q <= '0;
            {reg_q, data_q} <= table_word(entry_q);
          end else begin
            gap_cnt_q <= gap_cnt_d;
          end
        end
        S_REQ: begin
          // Timeout wins over a simultaneous done.
          if (tmo_hit) begin
            state_q <= S_ERROR;
            write_q <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_d;
            if (i2c_done) begin
              state_q <= S_RELEASE;
              write_q <= 1'b0;
            end
          end
        end
        S_RELEASE: begin
          if (tmo_hit) begin
            state_q <= S_ERROR;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_d;
            if (!i2c_done) begin
              if (entry_q == LAST_ENTRY) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q   <= S_GAP;
                entry_q   <= entry_d;
                gap_cnt_q <= '0;
              end
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          write_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign i2c_addr     = DEV_ADDR;
  assign i2c_register = reg_q;
  assign i2c_data     = data_q;
  assign i2c_write    = write_q;
  assign busy         = busy_q;
  assign cfg_done     = done_q;
  assign cfg_error    = error_q;
  assign entry_idx    = entry_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_codec_init_seq.sv
// ---------------------------------------------------------------------------
// tb_codec_init_seq
//   Directed bench for codec_init_seq with a behavioural I2C writer model.
//   Expected write words are queued when a sequence is launched; a monitor
//   pops and compares each time the DUT raises i2c_write.
// ---------------------------------------------------------------------------
module tb_codec_init_seq;

  localparam int GAP = 10;
  localparam int TMO = 200;
  localparam int RUN_BUDGET = 3000;

  // ---------------- clock / reset ----------------
  logic       sys_clk = 1'b0;
  logic       rst     = 1'b0;
  logic       start   = 1'b0;
  logic       i2c_done = 1'b0;
  logic [7:0] i2c_addr, i2c_register, i2c_data;
  logic       i2c_write, busy, cfg_done, cfg_error;
  logic [3:0] entry_idx;
  logic [2:0] state_dbg;
  int         cyc = 0;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  codec_init_seq #(
    .DEV_ADDR      (8'h34),
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .start       (start),
    .i2c_addr    (i2c_addr),
    .i2c_register(i2c_register),
    .i2c_data    (i2c_data),
    .i2c_write   (i2c_write),
    .i2c_done    (i2c_done),
    .busy        (busy),
    .cfg_done    (cfg_done),
    .cfg_error   (cfg_error),
    .entry_idx   (entry_idx),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] gold[9] = '{16'h1E00, 16'h0C00, 16'h0479, 16'h0679, 16'h0810,
                           16'h0A00, 16'h0E0A, 16'h1000, 16'h1201};
  int          writes_seen = 0;
  int          rise_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_run(input int first, input int last);
    for (int i = first; i <= last; i++) exp_q.push_back(gold[i]);
  endtask

  // ---------------- writer model ----------------
  // mode 0: done 40 cycles after write, drops 2 cycles after write falls
  // mode 1: as mode 0 but never answers entry stall_idx
  // mode 2: done held high before each request, pulsed low after write falls
  int wr_mode   = 0;
  int stall_idx = 3;

  initial begin
    int ph;
    int wcnt;
    ph = 0;
    wcnt = 0;
    forever begin
      @(negedge sys_clk);
      case (ph)
        0: begin
          if (i2c_write) begin
            if (wr_mode == 2) ph = 2;
            else if (wr_mode == 1 && int'(entry_idx) == stall_idx) ph = 5;
            else begin wcnt = 1; ph = 1; end
          end else if (wr_mode == 2) begin
            i2c_done = 1'b1;
          end
        end
        1: begin
          if (!i2c_write) ph = 0;
          else if (wcnt == 40) begin i2c_done = 1'b1; ph = 2; end
          else wcnt++;
        end
        2: if (!i2c_write) begin wcnt = 1; ph = 3; end
        3: begin
          if (wcnt == 2) begin i2c_done = 1'b0; ph = 0; end
          else wcnt++;
        end
        default: if (!i2c_write) ph = 0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic        wr_prev;
    logic [15:0] cap;
    logic [15:0] e;
    int          wlen;
    wr_prev = 1'b0;
    cap = '0;
    wlen = 0;
    forever begin
      @(negedge sys_clk);
      if (i2c_write && !wr_prev) begin
        rise_cyc = cyc;
        wlen = 1;
        cap = {i2c_register, i2c_data};
        writes_seen++;
        chk("i2c_addr", 32'(i2c_addr), 32'h34);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("[TB] FAIL unexpected_write: got 0x%0h expected no write", cap);
        end else begin
          e = exp_q.pop_front();
          chk("write_bytes", 32'(cap), 32'(e));
        end
      end else if (i2c_write) begin
        wlen++;
      end else if (wr_prev && busy) begin
        chk("bytes_stable", 32'({i2c_register, i2c_data}), 32'(cap));
        if (wr_mode == 2) chk("early_req_len", 32'(wlen), 32'd1);
      end
      wr_prev = i2c_write;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge sys_clk);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int n;
    n = 0;
    while (!(cfg_done || cfg_error) && n < RUN_BUDGET) begin
      @(negedge sys_clk);
      n++;
    end
    chk(name, 32'(cfg_done | cfg_error), 32'd1);
  endtask

  task automatic full_run(input string name);
    writes_seen = 0;
    push_run(0, 8);
    pulse_start();
    chk({name, "_flags_cleared"}, 32'({cfg_done, cfg_error, busy}), 32'b001);
    chk({name, "_idx0"}, 32'(entry_idx), 32'd0);
    wait_end({name, "_end"});
    chk({name, "_cfg_done"}, 32'({cfg_done, cfg_error}), 32'b10);
    chk({name, "_idx8"}, 32'(entry_idx), 32'd8);
    chk({name, "_writes"}, 32'(writes_seen), 32'd9);
    chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    // reset state
    rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("reset_write", 32'(i2c_write), 32'd0);
    chk("reset_flags", 32'({busy, cfg_done, cfg_error}), 32'd0);
    chk("reset_idx", 32'(entry_idx), 32'd0);
    chk("reset_state", 32'(state_dbg), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge sys_clk);

    // 1: normal run
    wr_mode = 0;
    full_run("run1");
    chk("run1_busy", 32'(busy), 32'd0);

    // 2: writer never answers entry 3
    wr_mode = 1;
    stall_idx = 3;
    push_run(0, 3);
    pulse_start();
    wait_end("tmo_end");
    chk("tmo_latency", 32'(cyc - rise_cyc), 32'd200);
    chk("tmo_flags", 32'({cfg_done, cfg_error}), 32'b01);
    chk("tmo_idx", 32'(entry_idx), 32'd3);
    chk("tmo_write", 32'(i2c_write), 32'd0);
    chk("tmo_state", 32'(state_dbg), 32'd5);
    chk("tmo_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (20) @(negedge sys_clk);
    chk("tmo_idx_frozen", 32'(entry_idx), 32'd3);

    // 5: restart from ERROR, then from DONE
    wr_mode = 0;
    full_run("from_error");
    repeat (5) @(negedge sys_clk);
    full_run("from_done");

    // 3: reset during entry 4 request
    push_run(0, 4);
    pulse_start();
    n = 0;
    while (!(entry_idx == 4'd4 && i2c_write) && n < RUN_BUDGET) begin
      @(negedge sys_clk);
      n++;
    end
    chk("rst_reached_entry4", 32'(entry_idx == 4'd4 && i2c_write), 32'd1);
    @(negedge sys_clk);
    rst = 1'b0;
    @(negedge sys_clk);
    chk("midrst_write", 32'(i2c_write), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_idx", 32'(entry_idx), 32'd0);
    rst = 1'b1;
    chk("midrst_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (5) @(negedge sys_clk);
    full_run("after_rst");

    // 4a: start held high for 1000 cycles
    writes_seen = 0;
    push_run(0, 8);
    @(negedge sys_clk);
    start = 1'b1;
    repeat (1000) @(negedge sys_clk);
    start = 1'b0;
    chk("held_done", 32'(cfg_done), 32'd1);
    chk("held_writes", 32'(writes_seen), 32'd9);
    chk("held_queue_empty", 32'(exp_q.size()), 32'd0);

    // 4b: extra start pulses while busy
    writes_seen = 0;
    push_run(0, 8);
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      repeat (90) @(negedge sys_clk);
      pulse_start();
    end
    chk("pulses_busy", 32'(busy), 32'd1);
    wait_end("pulses_end");
    repeat (100) @(negedge sys_clk);
    chk("pulses_writes", 32'(writes_seen), 32'd9);
    chk("pulses_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("pulses_done", 32'(cfg_done), 32'd1);

    // 6: done already high when each request is raised
    wr_mode = 2;
    repeat (3) @(negedge sys_clk);
    full_run("early_done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
